// File: rtl/csa_accumulator_pkg.sv
// Shared types and constants for the carry-save accumulator.
//   state_t    : controller state (ACCUM, RESOLVE, DONE), also exported on the
//                top-level debug port so checkers can bind to it.
//   OP_COUNT_W : width of the saturating operand counter.
package csa_accumulator_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int OP_COUNT_W = 16;

endpackage

// File: rtl/csa_stage.sv
// One level of 3:2 carry-save compression across WIDTH bits.
// Ports:
//   a, b, c : three addends
//   sum     : bitwise sum (a ^ b ^ c)
//   carry   : majority vector shifted left by one; the carry out of the top
//             bit is dropped, giving modulo 2^WIDTH arithmetic.
// Purely combinational; sum + carry == a + b + c (mod 2^WIDTH).
module csa_stage #(
  parameter int WIDTH = 40
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  // Only the lower WIDTH-1 majority bits survive the left shift.
  logic [WIDTH-2:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a[WIDTH-2:0] & b[WIDTH-2:0])
               | (a[WIDTH-2:0] & c[WIDTH-2:0])
               | (b[WIDTH-2:0] & c[WIDTH-2:0]);
  assign carry = {maj, 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand accumulator holding its running total in carry-save form.
// Operands are absorbed one per cycle with no carry propagation; after the
// last operand the redundant pair is resolved CHUNK bits per cycle and the
// binary result is offered on a valid/ready output.
// Ports:
//   CLK, nRST            : clock, synchronous active-low reset
//   clear                : synchronous abort, returns to empty ACCUM
//   in_valid/in_ready    : operand handshake (operand, is_signed, in_last)
//   out_valid/out_ready  : result handshake (result, op_count)
//   result               : resolved total modulo 2^ACC_WIDTH
//   op_count             : operands accepted, saturating
//   state                : controller state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid are registered and never depend on the
// same-cycle in_valid/out_ready; once out_valid rises, result and op_count
// hold until the transfer edge.
module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int ACC_WIDTH = 40,
  parameter int CHUNK     = 8
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_WIDTH-1:0]  operand,
  input  logic                  is_signed,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  result,
  output logic [OP_COUNT_W-1:0] op_count,
  output state_t                state
);

  localparam int NCHUNK = ACC_WIDTH / CHUNK;
  localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NCHUNK - 1);

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  sum_r, carry_r, result_r;
  logic [ACC_WIDTH-1:0]  ext_op, csa_sum, csa_carry;
  logic [OP_COUNT_W-1:0] count_r;
  logic [K_W-1:0]        k_r;
  logic                  rcarry_r;
  logic                  in_ready_r, out_valid_r;
  logic                  accept, zero_all;
  logic [CHUNK:0]        chunk_sum;

  // Reset and clear share one path: both return to an empty accumulation.
  assign zero_all = !nRST || clear;
  assign accept   = in_valid && in_ready_r;

  assign ext_op = is_signed ? ACC_WIDTH'($signed(operand)) : ACC_WIDTH'(operand);

  csa_stage #(.WIDTH(ACC_WIDTH)) u_stage (
    .a     (sum_r),
    .b     (carry_r),
    .c     (ext_op),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // One CHUNK-bit ripple slice per RESOLVE cycle; bit CHUNK is the carry
  // handed to the next slice.
  assign chunk_sum = {1'b0, sum_r[int'(k_r)*CHUNK +: CHUNK]}
                   + {1'b0, carry_r[int'(k_r)*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, rcarry_r};

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && in_last) state_d = RESOLVE;
      RESOLVE: if (k_r == K_LAST)     state_d = DONE;
      DONE:    if (out_ready)         state_d = ACCUM;
      default:                        state_d = ACCUM;
    endcase
    if (zero_all) state_d = ACCUM;
  end

  always_ff @(posedge CLK) begin
    if (zero_all) begin
      sum_r       <= '0;
      carry_r     <= '0;
      result_r    <= '0;
      count_r     <= '0;
      k_r         <= '0;
      rcarry_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      // Flags follow the next state so they are valid in the same cycle the
      // state register changes.
      in_ready_r  <= (state_d == ACCUM);
      out_valid_r <= (state_d == DONE);
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            sum_r    <= csa_sum;
            carry_r  <= csa_carry;
            if (count_r != '1) count_r <= count_r + OP_COUNT_W'(1);
            k_r      <= '0;
            rcarry_r <= 1'b0;
          end
        end
        RESOLVE: begin
          // The carry out of the final chunk is discarded by the next
          // accumulation clearing rcarry_r (wrap-around).
          result_r[int'(k_r)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          rcarry_r <= chunk_sum[CHUNK];
          k_r      <= k_r + K_W'(1);
        end
        DONE: begin
          if (out_ready) begin
            sum_r    <= '0;
            carry_r  <= '0;
            result_r <= '0;
            count_r  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign op_count  = count_r;
  assign state     = state_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Testbench for csa_accumulator: a default 32/40/8 instance and a small
// 8/8/4 instance for wrap-around cases. Expected results come from a plain
// integer running-sum model and are queued per accumulation; a monitor pops
// and compares on every output transfer.
module tb_csa_accumulator;
  import csa_accumulator_pkg::*;

  localparam int BW  = 32;
  localparam int AW  = 40;
  localparam int CW  = 8;
  localparam int NCH = AW / CW;
  localparam int SBW = 8;
  localparam int SAW = 8;
  localparam int SCW = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic clear = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- main DUT ----------------
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] operand = '0;
  logic          is_signed = 1'b0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] result;
  logic [15:0]   op_count;
  state_t        state;

  csa_accumulator #(.BIT_WIDTH(BW), .ACC_WIDTH(AW), .CHUNK(CW)) dut (
    .CLK(CLK), .nRST(nRST), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .operand(operand),
    .is_signed(is_signed), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .op_count(op_count), .state(state)
  );

  // ---------------- small DUT ----------------
  logic           s_in_valid = 1'b0;
  logic           s_in_ready;
  logic [SBW-1:0] s_operand = '0;
  logic           s_is_signed = 1'b0;
  logic           s_in_last = 1'b0;
  logic           s_out_valid;
  logic           s_out_ready = 1'b1;
  logic [SAW-1:0] s_result;
  logic [15:0]    s_op_count;
  state_t         s_state;

  csa_accumulator #(.BIT_WIDTH(SBW), .ACC_WIDTH(SAW), .CHUNK(SCW)) dut_s (
    .CLK(CLK), .nRST(nRST), .clear(clear),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .operand(s_operand),
    .is_signed(s_is_signed), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .op_count(s_op_count), .state(s_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;
  int ov_cycles = 0;

  logic [AW+15:0]  exp_q[$];
  logic [SAW+15:0] s_exp_q[$];
  logic [AW-1:0]   m_acc = '0;
  int              m_cnt = 0;
  logic [SAW-1:0]  sm_acc = '0;
  int              sm_cnt = 0;
  logic [AW+15:0]  mon_e;
  logic [SAW+15:0] s_mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- driver tasks (start/end at posedge + 1) ----------------
  task automatic send(input logic [BW-1:0] v, input bit s, input bit last);
    int guard;
    logic [AW-1:0] e;
    guard = 0;
    in_valid = 1'b1; operand = v; is_signed = s; in_last = last;
    @(negedge CLK);
    while (!in_ready && guard < 64) begin
      stalls++;
      guard++;
      @(negedge CLK);
    end
    if (!in_ready) fail_now("send_accept");
    @(posedge CLK); #1;
    in_valid = 1'b0; in_last = 1'b0;
    e = s ? AW'($signed(v)) : AW'(v);
    m_acc = m_acc + e;
    if (m_cnt < 65535) m_cnt++;
    if (last) begin
      exp_q.push_back({16'(m_cnt), m_acc});
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  task automatic s_send(input logic [SBW-1:0] v, input bit last);
    int guard;
    guard = 0;
    s_in_valid = 1'b1; s_operand = v; s_is_signed = 1'b0; s_in_last = last;
    @(negedge CLK);
    while (!s_in_ready && guard < 64) begin
      guard++;
      @(negedge CLK);
    end
    if (!s_in_ready) fail_now("s_send_accept");
    @(posedge CLK); #1;
    s_in_valid = 1'b0; s_in_last = 1'b0;
    sm_acc = sm_acc + v;
    if (sm_cnt < 65535) sm_cnt++;
    if (last) begin
      s_exp_q.push_back({16'(sm_cnt), sm_acc});
      sm_acc = '0;
      sm_cnt = 0;
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || s_exp_q.size() != 0) && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (exp_q.size() != 0 || s_exp_q.size() != 0) fail_now("drain");
  endtask

  // ---------------- monitors ----------------
  always @(negedge CLK) begin : mon_main
    if (out_valid) ov_cycles++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h, expected no result", result);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", result, mon_e[AW-1:0]);
        check("op_count", op_count, mon_e[AW+15:AW]);
      end
    end
  end

  always @(negedge CLK) begin : mon_small
    if (s_out_valid && s_out_ready) begin
      if (s_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL s_unexpected_result: got 0x%0h, expected no result", s_result);
      end else begin
        s_mon_e = s_exp_q.pop_front();
        check("s_result", s_result, s_mon_e[SAW-1:0]);
        check("s_op_count", s_op_count, s_mon_e[SAW+15:SAW]);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main_seq
    int ov_before;
    logic [BW-1:0] rv;

    // Reset values
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_op_count", op_count, 0);
    check("rst_state", state, ACCUM);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // 5 + 7 + 9 with the consumer stalled: latency, then hold under backpressure
    out_ready = 1'b0;
    send(5, 1'b0, 1'b0);
    send(7, 1'b0, 1'b0);
    send(9, 1'b0, 1'b1);
    // negedge k follows edge t+k, t being the accept edge of the last operand
    for (int k = 0; k <= NCH; k++) begin
      @(negedge CLK);
      if (k < NCH) check("latency_early", out_valid, 0);
      else         check("latency_due", out_valid, 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("hold_result", result, 21);
      check("hold_op_count", op_count, 3);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_op_count", op_count, 0);
    check("post_hs_result", result, 0);
    check("post_hs_out_valid", out_valid, 0);
    @(posedge CLK); #1;
    send(3, 1'b0, 1'b1);
    wait_drain();

    // Sign versus zero extension
    send(32'hFFFF_FFFF, 1'b1, 1'b0);
    send(32'd2, 1'b1, 1'b1);
    wait_drain();
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b1);
    wait_drain();

    // clear in ACCUM beats an offered operand
    send(50, 1'b0, 1'b0);
    in_valid = 1'b1; operand = 77; in_last = 1'b0; clear = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; clear = 1'b0;
    m_acc = '0; m_cnt = 0;
    @(negedge CLK);
    check("clear_accum_op_count", op_count, 0);
    @(posedge CLK); #1;
    send(4, 1'b0, 1'b1);
    wait_drain();

    // clear during RESOLVE chunk 2, then the same with nRST
    for (int pass = 0; pass < 2; pass++) begin
      send(10, 1'b0, 1'b0);
      send(20, 1'b0, 1'b1);
      void'(exp_q.pop_back());
      @(posedge CLK);
      @(posedge CLK); #1;
      check("abort_in_resolve", state, RESOLVE);
      if (pass == 0) clear = 1'b1;
      else           nRST = 1'b0;
      @(posedge CLK); #1;
      clear = 1'b0;
      nRST = 1'b1;
      @(negedge CLK);
      check("abort_state", state, ACCUM);
      check("abort_result", result, 0);
      check("abort_op_count", op_count, 0);
      check("abort_in_ready", in_ready, 1);
      ov_before = ov_cycles;
      repeat (10) @(negedge CLK);
      check("abort_no_out_valid", ov_cycles, ov_before);
      @(posedge CLK); #1;
    end

    // Streaming: 1000 random signed operands back to back
    stalls = 0;
    for (int i = 0; i < 1000; i++) begin
      rv = $urandom();
      if (i < 8) rv = (i % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      send(rv, 1'b1, i == 999);
    end
    check("stream_stalls", stalls, 0);
    wait_drain();

    // Narrow instance: wrap-around modulo 2^8
    s_send(200, 1'b0);
    s_send(100, 1'b1);
    wait_drain();
    for (int i = 0; i < 256; i++) s_send(8'hFF, i == 255);
    wait_drain();

    repeat (5) @(negedge CLK);
    check("leftover_expected", exp_q.size() + s_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
